// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the downstream stream port of fifo_stream_reader.
// master = the reader itself, slave = the FIFO/sink environment around it.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  // FIFO read port: fifo_rd_data is valid exactly one cycle after fifo_rdreq.
  logic                  fifo_rdreq;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;

  // Stream port: a word moves when out_valid && out_ready on a rising edge;
  // once out_valid is high, out_data/out_last hold until that transfer.
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [15:0]           word_count;

  modport master (
    output fifo_rdreq,
    input  fifo_rd_data,
    input  fifo_empty,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last,
    output word_count
  );

  modport slave (
    input  fifo_rdreq,
    output fifo_rd_data,
    output fifo_empty,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last,
    input  word_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Turns a FIFO with a one-cycle read latency into a valid/ready stream through a
// two-entry skid buffer, framing packets of PKT_LEN words and counting transfers.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input  logic                   rd_clk,
  input  logic                   aclr_n,
  input  logic                   sclr,
  fifo_stream_reader_if.master   bus
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_q   [2];
  logic [DATA_WIDTH-1:0] buf_nxt [2];
  logic [1:0]            occ_q, occ_nxt;
  logic                  infl_q, infl_nxt;
  logic [15:0]           idx_q, idx_nxt;
  logic [15:0]           wcnt_q, wcnt_nxt;
  logic                  valid_q, valid_nxt;
  logic                  last_q, last_nxt;

  logic                  pop;
  logic                  rdreq;
  logic [2:0]            committed;
  logic [2:0]            limit;

  assign pop = valid_q && bus.out_ready;

  // Buffered plus in-flight words may never exceed the two slots, counting the
  // slot freed by a pop this same cycle.
  assign committed = {1'b0, occ_q} + {2'b00, infl_q};
  assign limit     = 3'd2 + {2'b00, pop};
  assign rdreq     = aclr_n && !sclr && !bus.fifo_empty && (committed < limit);

  always_comb begin
    buf_nxt   = buf_q;
    occ_nxt   = occ_q;
    idx_nxt   = idx_q;
    wcnt_nxt  = wcnt_q;
    infl_nxt  = rdreq;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;

    if (pop) begin
      buf_nxt[0] = buf_q[1];
      occ_nxt    = occ_q - 2'd1;
      idx_nxt    = (idx_q == LAST_IDX) ? 16'd0 : idx_q + 16'd1;
      wcnt_nxt   = wcnt_q + 16'd1;
    end

    // A returning word lands behind whatever remains after the pop; a full
    // buffer keeps its contents and the word is dropped.
    if (infl_q && (occ_nxt != 2'd2)) begin
      buf_nxt[occ_nxt[0]] = bus.fifo_rd_data;
      occ_nxt             = occ_nxt + 2'd1;
    end

    if (sclr) begin
      occ_nxt  = 2'd0;
      idx_nxt  = 16'd0;
      wcnt_nxt = 16'd0;
      infl_nxt = 1'b0;
    end

    valid_nxt = (occ_nxt != 2'd0);
    last_nxt  = valid_nxt && (idx_nxt == LAST_IDX);
  end

  always_ff @(posedge rd_clk or negedge aclr_n) begin
    if (!aclr_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      occ_q    <= 2'd0;
      infl_q   <= 1'b0;
      idx_q    <= 16'd0;
      wcnt_q   <= 16'd0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      buf_q[0] <= buf_nxt[0];
      buf_q[1] <= buf_nxt[1];
      occ_q    <= occ_nxt;
      infl_q   <= infl_nxt;
      idx_q    <= idx_nxt;
      wcnt_q   <= wcnt_nxt;
      valid_q  <= valid_nxt;
      last_q   <= last_nxt;
    end
  end

  assign bus.fifo_rdreq = rdreq;
  assign bus.out_data   = buf_q[0];
  assign bus.out_valid  = valid_q;
  assign bus.out_last   = last_q;
  assign bus.word_count = wcnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a one-cycle-latency FIFO model feeds the
// reader and a monitor collects transferred words for in-order comparison.
module tb_fifo_stream_reader;

  logic rd_clk;
  logic aclr_n;
  logic sclr;
  logic empty_force;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(4)) dut (
    .rd_clk (rd_clk),
    .aclr_n (aclr_n),
    .sclr   (sclr),
    .bus    (bus)
  );

  // clock / reset
  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  // FIFO model
  logic [7:0] fifo_mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr) || empty_force;

  always @(posedge rd_clk) begin
    if (bus.fifo_rdreq) begin
      bus.fifo_rd_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  // scoreboard
  logic [7:0] exp_q  [$];
  logic [7:0] got_q  [$];
  logic       last_q [$];
  int checks   = 0;
  int failures = 0;
  int pulses;

  always @(posedge rd_clk) begin
    if (aclr_n && !sclr && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      last_q.push_back(bus.out_last);
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    last_q.delete();
  endtask

  initial begin
    aclr_n           = 1'b0;
    sclr             = 1'b0;
    empty_force      = 1'b0;
    bus.out_ready    = 1'b0;
    bus.fifo_rd_data = 8'h00;

    // reset state, FIFO already holding 0x01..0x05
    for (int i = 1; i <= 5; i++) push(8'(i));
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last",  32'(bus.out_last),  32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_wcnt",  32'(bus.word_count), 32'd0);
    chk("rst_rdreq", 32'(bus.fifo_rdreq), 32'd0);

    // preloaded stream at full rate
    aclr_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("t1_rdreq_first", 32'(bus.fifo_rdreq), 32'd1);
    tick();
    chk("t1_valid_lat1", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t1_valid%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t1_data%0d", i),  32'(bus.out_data), 32'(i));
    end
    tick();
    chk("t1_valid_end", 32'(bus.out_valid), 32'd0);
    chk("t1_wcnt", 32'(bus.word_count), 32'd5);
    sb_check("t1");

    // backpressure: only two words may be pulled while stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    #1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fifo_rdreq) pulses++;
      tick();
      if (i == 4) chk("t2_data_mid", 32'(bus.out_data), 32'h10);
    end
    chk("t2_pulses", 32'(pulses), 32'd2);
    chk("t2_valid",  32'(bus.out_valid), 32'd1);
    chk("t2_data",   32'(bus.out_data), 32'h10);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    sb_check("t2");
    chk("t2_wcnt", 32'(bus.word_count), 32'd9);

    // packet framing, PKT_LEN = 4
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("t3_sclr_wcnt", 32'(bus.word_count), 32'd0);
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 14; i++) tick();
    chk("t3_last_count", 32'(last_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < last_q.size(); i++)
      chk($sformatf("t3_last%0d", i), 32'(last_q[i]), (i == 3 || i == 7) ? 32'd1 : 32'd0);
    sb_check("t3");
    chk("t3_wcnt", 32'(bus.word_count), 32'd10);

    // sclr the cycle after a request: returning word dropped
    fifo_mem[wr_ptr[7:0]] = 8'h30;
    wr_ptr = wr_ptr + 1;
    push(8'h31);
    #1;
    chk("t4_rdreq", 32'(bus.fifo_rdreq), 32'd1);
    tick();
    sclr = 1'b1;
    #1;
    chk("t4_rdreq_sclr", 32'(bus.fifo_rdreq), 32'd0);
    tick();
    sclr = 1'b0;
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_wcnt",  32'(bus.word_count), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    sb_check("t4");
    chk("t4_wcnt_after", 32'(bus.word_count), 32'd1);

    // toggling empty flag with random backpressure
    for (int i = 0; i < 12; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 60; i++) begin
      empty_force   = ~empty_force;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("t5_rdreq_empty", 32'(bus.fifo_rdreq && bus.fifo_empty), 32'd0);
      tick();
    end
    empty_force   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    sb_check("t5");
    chk("t5_wcnt", 32'(bus.word_count), 32'd13);

    // asynchronous reset mid-stream: 0x51 buffered and 0x52 in flight are lost
    fifo_mem[wr_ptr[7:0]] = 8'h50; wr_ptr = wr_ptr + 1; exp_q.push_back(8'h50);
    fifo_mem[wr_ptr[7:0]] = 8'h51; wr_ptr = wr_ptr + 1;
    fifo_mem[wr_ptr[7:0]] = 8'h52; wr_ptr = wr_ptr + 1;
    for (int i = 3; i < 8; i++) push(8'h50 + 8'(i));
    tick();
    tick();
    chk("t6_data_pre", 32'(bus.out_data), 32'h50);
    tick();
    chk("t6_data_pre2", 32'(bus.out_data), 32'h51);
    #1;
    aclr_n = 1'b0;
    #1;
    chk("t6_arst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_arst_data",  32'(bus.out_data),  32'd0);
    chk("t6_arst_last",  32'(bus.out_last),  32'd0);
    chk("t6_arst_wcnt",  32'(bus.word_count), 32'd0);
    chk("t6_arst_rdreq", 32'(bus.fifo_rdreq), 32'd0);
    tick();
    tick();
    chk("t6_hold_valid", 32'(bus.out_valid), 32'd0);
    aclr_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    sb_check("t6");
    chk("t6_wcnt", 32'(bus.word_count), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
